// File: rtl/z_core_pkg.sv
// -----------------------------------------------------------------------------
// z_core_pkg
// Shared definitions for the core instruction decoder and encoder:
//   - instruction format codes (FMT_R .. FMT_J); codes 6 and 7 are illegal
//   - RV32I major opcode constants
//   - canonical NOP word (addi x0, x0, 0)
//   - fmt_is_legal(): true for the six defined format codes
// -----------------------------------------------------------------------------
package z_core_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic fmt_is_legal(input logic [2:0] fmt);
        return (fmt <= 3'(FMT_J));
    endfunction

endpackage

// File: rtl/z_core_imm_pack.sv
// -----------------------------------------------------------------------------
// z_core_imm_pack
// Combinational immediate placement for the RV32I encoder.
// Scatters the immediate into its instruction-word bit positions for the
// selected format and reports which word bits belong to the immediate.
// The mask is what lets the encoder drop register/funct fields that the
// format does not carry.
//
// Optional feature (macro Z_ENC_RANGE_CHECK_EN):
//   defined   -> o_range_err flags immediates the format cannot represent
//   undefined -> o_range_err is tied low, no range logic is built
//
// Ports:
//   i_fmt        in  3   format code (0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal)
//   i_imm        in  32  immediate (byte offset for B/J, full value for U)
//   o_imm_word   out 32  immediate bits in place, all other bits zero
//   o_imm_mask   out 32  1 where the word bit is taken from the immediate
//   o_range_err  out 1   immediate not representable in the format
// -----------------------------------------------------------------------------
module z_core_imm_pack
    import z_core_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [31:0] i_imm,
    output logic [31:0] o_imm_word,
    output logic [31:0] o_imm_mask,
    output logic        o_range_err
);

    always_comb begin
        o_imm_word = '0;
        o_imm_mask = '0;
        case (i_fmt)
            FMT_I: begin
                o_imm_word = {i_imm[11:0], 20'b0};
                o_imm_mask = 32'hFFF0_0000;
            end
            FMT_S: begin
                o_imm_word = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
                o_imm_mask = 32'hFE00_0F80;
            end
            FMT_B: begin
                o_imm_word = {i_imm[12], i_imm[10:5], 13'b0,
                              i_imm[4:1], i_imm[11], 7'b0};
                o_imm_mask = 32'hFE00_0F80;
            end
            FMT_U: begin
                o_imm_word = {i_imm[31:12], 12'b0};
                o_imm_mask = 32'hFFFF_F000;
            end
            FMT_J: begin
                o_imm_word = {i_imm[20], i_imm[10:1], i_imm[11],
                              i_imm[19:12], 12'b0};
                o_imm_mask = 32'hFFFF_F000;
            end
            default: begin
                // R format and illegal codes carry no immediate
                o_imm_word = '0;
                o_imm_mask = '0;
            end
        endcase
    end

`ifdef Z_ENC_RANGE_CHECK_EN
    // True when v is the sign extension of its low w bits: after an
    // arithmetic shift by w-1 only the sign remains (all zeros or all ones).
    function automatic logic fits_signed(input logic [31:0] v, input int w);
        logic signed [31:0] sv;
        logic signed [31:0] sh;
        sv = signed'(v);
        sh = sv >>> (w - 1);
        return (sh == 32'sd0) || (sh == -32'sd1);
    endfunction

    always_comb begin
        o_range_err = 1'b0;
        case (i_fmt)
            FMT_I, FMT_S: o_range_err = !fits_signed(i_imm, 12);
            FMT_B:        o_range_err = !fits_signed(i_imm, 13) || i_imm[0];
            FMT_J:        o_range_err = !fits_signed(i_imm, 21) || i_imm[0];
            FMT_U:        o_range_err = |i_imm[11:0];
            default:      o_range_err = 1'b0;
        endcase
    end
`else
    assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/z_core_encoder.sv
// -----------------------------------------------------------------------------
// z_core_encoder
// Packs opcode, register indices, funct fields and an immediate into a 32-bit
// RV32I instruction word. Two-stage valid/ready pipeline, one word per cycle,
// two cycles from accept to out_valid when unstalled.
//
// Optional feature (macro Z_ENC_RANGE_CHECK_EN): immediate range checking
// in z_core_imm_pack. Illegal format codes always give NOP_WORD with out_err.
//
// Parameters:
//   CNT_W     width of the emitted-word counter
//   NOP_WORD  word emitted for an illegal format code
//
// Ports:
//   clk        in  1      core clock
//   rst        in  1      asynchronous active-high reset
//   in_valid   in  1      request valid
//   in_ready   out 1      encoder accepts a request this cycle
//   fmt        in  3      0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   op         in  7      opcode, inst[6:0]
//   rd         in  5      destination register
//   rs1        in  5      source register 1
//   rs2        in  5      source register 2
//   funct3     in  3      function field
//   funct7     in  7      function field (R only)
//   imm        in  32     immediate
//   out_valid  out 1      encoded word valid
//   out_ready  in  1      consumer accepts word
//   inst       out 32     encoded instruction
//   out_err    out 1      immediate out of range or illegal fmt
//   enc_count  out CNT_W  words accepted by the consumer (wraps)
// -----------------------------------------------------------------------------
module z_core_encoder
    import z_core_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = NOP_INST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       op,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count
);

    logic             w_s1_load;
    logic             w_s2_load;

    logic [31:0]      w_imm_word;
    logic [31:0]      w_imm_mask;
    logic             w_range_err;
    logic             w_fmt_illegal;

    logic             r_vld_p1;
    logic [31:0]      r_imm_word_p1;
    logic [31:0]      r_imm_mask_p1;
    logic [6:0]       r_op_p1;
    logic [4:0]       r_rd_p1;
    logic [4:0]       r_rs1_p1;
    logic [4:0]       r_rs2_p1;
    logic [2:0]       r_funct3_p1;
    logic [6:0]       r_funct7_p1;
    logic             r_illegal_p1;
    logic             r_err_p1;

    logic [31:0]      w_fields_p1;
    logic [31:0]      w_word_p1;

    logic             r_vld_p2;
    logic [31:0]      r_inst_p2;
    logic             r_err_p2;
    logic [CNT_W-1:0] r_cnt;

    // Handshake: each stage may load when it is empty or its content moves on
    assign w_s2_load = !r_vld_p2 || out_ready;
    assign w_s1_load = !r_vld_p1 || w_s2_load;
    assign in_ready  = w_s1_load;

    z_core_imm_pack u_imm_pack (
        .i_fmt       (fmt),
        .i_imm       (imm),
        .o_imm_word  (w_imm_word),
        .o_imm_mask  (w_imm_mask),
        .o_range_err (w_range_err)
    );

    assign w_fmt_illegal = !fmt_is_legal(fmt);

    // ---- stage 1: request fields, placed immediate, error flag ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_load) begin
            r_vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_load && in_valid) begin
            r_imm_word_p1 <= w_imm_word;
            r_imm_mask_p1 <= w_imm_mask;
            r_op_p1       <= op;
            r_rd_p1       <= rd;
            r_rs1_p1      <= rs1;
            r_rs2_p1      <= rs2;
            r_funct3_p1   <= funct3;
            r_funct7_p1   <= funct7;
            r_illegal_p1  <= w_fmt_illegal;
            r_err_p1      <= w_fmt_illegal || w_range_err;
        end
    end

    // Fields sit at their fixed RV32I positions; wherever the format puts
    // immediate bits instead, the immediate mask knocks the field out, so
    // unused inputs can never leak into the word.
    assign w_fields_p1 = {r_funct7_p1, r_rs2_p1, r_rs1_p1,
                          r_funct3_p1, r_rd_p1, r_op_p1};
    assign w_word_p1   = r_illegal_p1 ? NOP_WORD
                       : ((w_fields_p1 & ~r_imm_mask_p1) | r_imm_word_p1);

    // ---- stage 2: assembled word and flag, held while stalled ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_inst_p2 <= '0;
            r_err_p2  <= 1'b0;
        end else if (w_s2_load) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_inst_p2 <= w_word_p1;
                r_err_p2  <= r_err_p1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_vld_p2 && out_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_vld_p2;
    assign inst      = r_inst_p2;
    assign out_err   = r_err_p2;
    assign enc_count = r_cnt;

endmodule

// File: tb/tb_z_core_encoder.sv
// -----------------------------------------------------------------------------
// tb_z_core_encoder
// Self-checking bench for z_core_encoder. A format-level model predicts each
// accepted request's word and error flag; a compare process on the falling
// edge checks in_ready, enc_count and every presented word against it.
// Directed requests also carry hand-computed literal words.
// -----------------------------------------------------------------------------
module tb_z_core_encoder;

    localparam int CNT_W = 16;
`ifdef Z_ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       fmt;
    logic [6:0]       op;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      inst;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;

    always #5 clk = ~clk;

    z_core_encoder #(
        .CNT_W    (CNT_W),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .op        (op),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .out_err   (out_err),
        .enc_count (enc_count)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t             q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    int               n_tests = 0;
    int               n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Straight from the RV32I field tables: place each field bit by bit,
    // judge range by plain signed comparisons.
    function automatic exp_t model(input logic [2:0] f, input logic [6:0] o,
                                   input logic [4:0] d, input logic [4:0] s1,
                                   input logic [4:0] s2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] im);
        exp_t        e;
        logic [31:0] w;
        int          s;
        bit          bad;
        w   = '0;
        bad = 1'b0;
        s   = $signed(im);
        w[6:0] = o;
        case (f)
            3'd0: begin
                w[11:7] = d; w[14:12] = f3; w[19:15] = s1; w[24:20] = s2; w[31:25] = f7;
            end
            3'd1: begin
                w[11:7] = d; w[14:12] = f3; w[19:15] = s1; w[31:20] = im[11:0];
                bad = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w[14:12] = f3; w[19:15] = s1; w[24:20] = s2;
                w[31:25] = im[11:5]; w[11:7] = im[4:0];
                bad = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w[14:12] = f3; w[19:15] = s1; w[24:20] = s2;
                w[31] = im[12]; w[30:25] = im[10:5]; w[11:8] = im[4:1]; w[7] = im[11];
                bad = (s < -4096) || (s > 4095) || im[0];
            end
            3'd4: begin
                w[11:7] = d; w[31:12] = im[31:12];
                bad = (im[11:0] != 12'd0);
            end
            3'd5: begin
                w[11:7] = d;
                w[31] = im[20]; w[30:21] = im[10:1]; w[20] = im[11]; w[19:12] = im[19:12];
                bad = (s < -1048576) || (s > 1048575) || im[0];
            end
            default: w = 32'h0000_0013;
        endcase
        e.inst = w;
        e.err  = (f > 3'd5) ? 1'b1 : (RC & bad);
        return e;
    endfunction

    // Compare process: falling edge, inputs and state are stable here and
    // describe exactly what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_cnt = '0;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_enc_count", 32'(enc_count), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            chk("in_ready", 32'(in_ready), 32'((q.size() == 2 && !out_ready) ? 1'b0 : 1'b1));
            chk("enc_count", 32'(enc_count), 32'(exp_cnt));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("inst_vs_model", inst, q[0].inst);
                    chk("err_vs_model", 32'(out_err), 32'(q[0].err));
                    if (out_ready) begin
                        void'(q.pop_front());
                        exp_cnt = exp_cnt + 1'b1;
                    end
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(fmt, op, rd, rs1, rs2, funct3, funct7, imm));
        end
    end

    task automatic set_req(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] im);
        fmt = f; op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic send(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                        input logic [31:0] im);
        bit ok;
        ok = 1'b0;
        set_req(f, o, d, 5'd3, 5'd4, 3'd0, 7'd0, im);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            chk("send_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    // One request into an empty pipeline with out_ready high; checks the
    // model against the literal and the DUT word two cycles after accept.
    task automatic run_one(input string nm, input logic [2:0] f, input logic [6:0] o,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                           input logic [31:0] x_inst, input logic x_err);
        exp_t m;
        m = model(f, o, d, s1, s2, f3, f7, im);
        chk({nm, "_model_inst"}, m.inst, x_inst);
        chk({nm, "_model_err"}, 32'(m.err), 32'(x_err));
        set_req(f, o, d, s1, s2, f3, f7, im);
        in_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({nm, "_lat1_out_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_lat2_out_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_inst"}, inst, x_inst);
        chk({nm, "_err"}, 32'(out_err), 32'(x_err));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (q.size() != 0 || out_valid); i++) @(posedge clk);
        #1;
        chk("drain_done", 32'((q.size() == 0) && !out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_inst", inst, 32'd0);
        chk("reset_out_err", 32'(out_err), 32'd0);
        chk("reset_enc_count", 32'(enc_count), 32'd0);
        rst = 1'b0;

        // Directed words; unused fields carry junk that must not show up
        run_one("I_addi",  3'd1, 7'h13, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 32'd5,         32'h0050_0093, 1'b0);
        run_one("S_sw",    3'd2, 7'h23, 5'd31, 5'd1,  5'd2,  3'd2, 7'h7F, 32'd8,         32'h0020_A423, 1'b0);
        run_one("B_m4",    3'd3, 7'h63, 5'd31, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        run_one("J_jal",   3'd5, 7'h6F, 5'd1,  5'd31, 5'd31, 3'd7, 7'h7F, 32'd8,         32'h0080_00EF, 1'b0);
        run_one("U_lui",   3'd4, 7'h37, 5'd5,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        run_one("R_sub",   3'd0, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0);
        run_one("I_2048",  3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd2048,      32'h8000_0093, RC);
        run_one("B_6",     3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'd6,         32'h0000_0363, 1'b0);
        run_one("B_7",     3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'd7,         32'h0000_0363, RC);
        run_one("U_low",   3'd4, 7'h37, 5'd5,  5'd0,  5'd0,  3'd0, 7'h00, 32'h1234_5678, 32'h1234_52B7, RC);
        run_one("J_2p20",  3'd5, 7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0010_0000, 32'h8000_006F, RC);
        run_one("fmt7",    3'd7, 7'h33, 5'd9,  5'd9,  5'd9,  3'd5, 7'h11, 32'h0000_0123, 32'h0000_0013, 1'b1);
        run_one("fmt6",    3'd6, 7'h6F, 5'd1,  5'd2,  5'd3,  3'd1, 7'h01, 32'd4,         32'h0000_0013, 1'b1);

        // Full-rate stream with the consumer always ready
        for (int i = 0; i < 5; i++) send(3'd1, 7'h13, 5'(i + 1), 32'(i * 3));
        drain();

        // Backpressure: clear the counter, then 4 back-to-back requests
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fork
            begin
                send(3'd1, 7'h13, 5'd10, 32'd1);
                send(3'd1, 7'h13, 5'd11, 32'd2);
                chk("bp_in_ready_after_2nd", 32'(in_ready), 32'd0);
                send(3'd1, 7'h13, 5'd12, 32'd3);
                send(3'd1, 7'h13, 5'd13, 32'd4);
            end
            begin
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_enc_count", 32'(enc_count), 32'd4);

        // Reset with both stages full
        out_ready = 1'b0;
        send(3'd4, 7'h37, 5'd7, 32'hABCD_E000);
        send(3'd5, 7'h6F, 5'd8, 32'd16);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_enc_count", 32'(enc_count), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        run_one("post_rst", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h0050_0093, 1'b0);
        drain();
        chk("post_rst_enc_count", 32'(enc_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
